// File: rtl/sensor_trigger_sequencer_pkg.sv
// Shared types and constants for the sensor trigger sequencer.
// Pure declarations: no logic, no latency.
// Sensor index constants mirror the driver-side enumeration of enable bits.
package sensor_trigger_sequencer_pkg;

  // Default lane count and counter width
  localparam int N_SENSORS_DEF = 10;
  localparam int CNT_W_DEF     = 16;

  // Round sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Lane indices; must match the timing manager enable bit order
  localparam int SENSOR_ADC     = 0;
  localparam int SENSOR_ENCODER = 1;
  localparam int SENSOR_AMDS_0  = 2;
  localparam int SENSOR_AMDS_1  = 3;
  localparam int SENSOR_AMDS_2  = 4;
  localparam int SENSOR_AMDS_3  = 5;
  localparam int SENSOR_EDDY_0  = 6;
  localparam int SENSOR_EDDY_1  = 7;
  localparam int SENSOR_EDDY_2  = 8;
  localparam int SENSOR_EDDY_3  = 9;

endpackage

// File: rtl/sensor_trigger_sequencer_lane.sv
// One sensor lane: delayed start pulse, completion capture, timeout flag.
// Start pulse is registered: one cycle after elapsed matches the lane delay.
// No backpressure; done edges are captured the cycle after they are seen.
module sensor_seq_lane
  import sensor_trigger_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] elapsed,
  input  logic             run,
  input  logic             round_start,
  input  logic             timeout_hit,
  input  logic             clear,
  input  logic             done_raw,
  output logic             start,
  output logic             done,
  output logic             timeout_flag
);

  logic raw_q;
  logic started;
  logic start_hit;
  logic edge_hit;
  logic to_hit;

  // Lane events for this cycle. A lane already closed by timeout (done set
  // while unstarted) must never start, nor may one whose delay coincides
  // with the timeout cycle. A done edge in the timeout cycle beats the timeout.
  always_comb begin
    start_hit = run && en && !started && !done && !timeout_hit && (elapsed == delay);
    edge_hit  = run && en && started && done_raw && !raw_q;
    to_hit    = run && en && !done && timeout_hit && !edge_hit;
  end

  // Lane state: edge flop, start pulse, started/done tracking, sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q        <= 1'b0;
      started      <= 1'b0;
      start        <= 1'b0;
      done         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      raw_q <= done_raw;
      start <= start_hit;

      if (round_start) begin
        started <= 1'b0;
        done    <= 1'b0;
      end else begin
        if (start_hit) begin
          started <= 1'b1;
        end
        if (edge_hit || to_hit) begin
          done <= 1'b1;
        end
      end

      // A new timeout takes priority over a same-cycle clear
      if (to_hit) begin
        timeout_flag <= 1'b1;
      end else if (clear) begin
        timeout_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sensor_trigger_sequencer.sv
// Turns one acquisition trigger into staggered per-sensor starts and tracks completion.
// Starts land 2+delay_i cycles after the trigger; round_done 1 cycle after the last done.
// No backpressure: triggers outside IDLE are dropped and flagged as overrun.
module sensor_trigger_sequencer
  import sensor_trigger_sequencer_pkg::*;
#(
  parameter int N_SENSORS = N_SENSORS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trigger,
  input  logic [N_SENSORS-1:0]       en_bits,
  input  logic [N_SENSORS*CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0]           timeout_cfg,
  input  logic                       clear_flags,
  input  logic [N_SENSORS-1:0]       sensor_done_raw,
  output logic [N_SENSORS-1:0]       sensor_start,
  output logic [N_SENSORS-1:0]       sensor_done,
  output logic [N_SENSORS-1:0]       timeout_flags,
  output logic                       overrun,
  output logic                       busy,
  output logic                       round_done
);

  seq_state_t           state_q;
  seq_state_t           state_d;
  logic [CNT_W-1:0]     elapsed;
  logic [N_SENSORS-1:0] en_q;
  logic                 accept;
  logic                 run;
  logic                 timeout_hit;
  logic                 all_done;
  logic                 ovr_set;

  // Round-level qualifiers shared by every lane
  always_comb begin
    accept      = (state_q == ST_IDLE) && trigger && (en_bits != '0);
    run         = (state_q == ST_RUN);
    timeout_hit = run && (timeout_cfg != '0) && (elapsed == timeout_cfg);
    all_done    = &(sensor_done | ~en_q);
    ovr_set     = trigger && (state_q != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and round status outputs. RUN exits on the registered done
  // vector, so a timeout closes the round one cycle after the flags appear.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    round_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (all_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        round_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Elapsed counter: zeroed on accept, saturating count while running
  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed <= '0;
    end else if (accept) begin
      elapsed <= '0;
    end else if (run && (elapsed != {CNT_W{1'b1}})) begin
      elapsed <= elapsed + CNT_W'(1);
    end
  end

  // Enable snapshot for the round
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
    end else if (accept) begin
      en_q <= en_bits;
    end
  end

  // Sticky overrun; a new overrun beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (clear_flags) begin
      overrun <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSORS; gi++) begin : g_lane
      sensor_seq_lane #(
        .CNT_W(CNT_W)
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .en          (en_q[gi]),
        .delay       (delay_cfg[gi*CNT_W +: CNT_W]),
        .elapsed     (elapsed),
        .run         (run),
        .round_start (accept),
        .timeout_hit (timeout_hit),
        .clear       (clear_flags),
        .done_raw    (sensor_done_raw[gi]),
        .start       (sensor_start[gi]),
        .done        (sensor_done[gi]),
        .timeout_flag(timeout_flags[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sensor_trigger_sequencer.sv
// Self-checking bench for sensor_trigger_sequencer.
// Per-scenario vector tables drive inputs and check levels at fixed cycle offsets.
// Start pulses and round_done pulses are scoreboarded against expected-event queues.
module tb_sensor_trigger_sequencer;

  localparam int NS = 10;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              trigger;
  logic [NS-1:0]     en_bits;
  logic [NS*CW-1:0]  delay_cfg;
  logic [CW-1:0]     timeout_cfg;
  logic              clear_flags;
  logic [NS-1:0]     sensor_done_raw;
  logic [NS-1:0]     sensor_start;
  logic [NS-1:0]     sensor_done;
  logic [NS-1:0]     timeout_flags;
  logic              overrun;
  logic              busy;
  logic              round_done;

  logic [CW-1:0]     dly [NS];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          off;
    logic        drive;
    logic        r;
    logic        trig;
    logic [NS-1:0] en;
    logic [NS-1:0] raw;
    logic        clr;
    logic [NS-1:0] e_done;
    logic [NS-1:0] e_flags;
    logic        e_busy;
    logic        e_rdone;
    logic        e_ovr;
  } vec_t;

  typedef struct {
    int lane;
    int at;
  } ev_t;

  vec_t tbl[$];
  ev_t  start_q[$];
  int   rd_q[$];
  string scn;

  sensor_trigger_sequencer #(
    .N_SENSORS(NS),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trigger        (trigger),
    .en_bits        (en_bits),
    .delay_cfg      (delay_cfg),
    .timeout_cfg    (timeout_cfg),
    .clear_flags    (clear_flags),
    .sensor_done_raw(sensor_done_raw),
    .sensor_start   (sensor_start),
    .sensor_done    (sensor_done),
    .timeout_flags  (timeout_flags),
    .overrun        (overrun),
    .busy           (busy),
    .round_done     (round_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    delay_cfg = '0;
    for (int i = 0; i < NS; i++) delay_cfg[i*CW +: CW] = dly[i];
  end

  function automatic vec_t drv(int off, logic r, logic t, logic [NS-1:0] e,
                               logic [NS-1:0] raw, logic c);
    vec_t v;
    v = '{default: '0};
    v.off = off; v.drive = 1'b1; v.r = r; v.trig = t; v.en = e; v.raw = raw; v.clr = c;
    return v;
  endfunction

  function automatic vec_t chk(int off, logic [NS-1:0] d, logic [NS-1:0] f,
                               logic b, logic rd, logic ov);
    vec_t v;
    v = '{default: '0};
    v.off = off; v.drive = 1'b0; v.e_done = d; v.e_flags = f;
    v.e_busy = b; v.e_rdone = rd; v.e_ovr = ov;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_row(input vec_t v);
    cmp($sformatf("%s done @+%0d", scn, v.off),  32'(sensor_done),   32'(v.e_done));
    cmp($sformatf("%s flags @+%0d", scn, v.off), 32'(timeout_flags), 32'(v.e_flags));
    cmp($sformatf("%s busy @+%0d", scn, v.off),  32'(busy),          32'(v.e_busy));
    cmp($sformatf("%s round_done @+%0d", scn, v.off), 32'(round_done), 32'(v.e_rdone));
    cmp($sformatf("%s overrun @+%0d", scn, v.off), 32'(overrun),     32'(v.e_ovr));
  endtask

  // Walk the table cycle by cycle from the current negedge (offset 0 = trigger cycle)
  task automatic run_table(input int len);
    for (int c = 0; c <= len; c++) begin
      foreach (tbl[k]) if (tbl[k].off == c && !tbl[k].drive) check_row(tbl[k]);
      foreach (tbl[k]) begin
        if (tbl[k].off == c && tbl[k].drive) begin
          rst             = tbl[k].r;
          trigger         = tbl[k].trig;
          en_bits         = tbl[k].en;
          sensor_done_raw = tbl[k].raw;
          clear_flags     = tbl[k].clr;
        end
      end
      @(negedge clk);
    end
    tbl.delete();
  endtask

  task automatic push_start(input int lane, input int at);
    ev_t e;
    e.lane = lane;
    e.at   = at;
    start_q.push_back(e);
  endtask

  // Pulse monitor: every start / round_done pulse must match the next expected event
  always @(negedge clk) begin : mon
    ev_t e;
    for (int i = 0; i < NS; i++) begin
      if (sensor_start[i] === 1'b1) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected start: lane %0d at cycle %0d, required no start", i, cyc);
        end else begin
          e = start_q.pop_front();
          if (e.lane != i || e.at != cyc) begin
            errors++;
            $display("FAIL start event: lane %0d at cycle %0d, required lane %0d at cycle %0d",
                     i, cyc, e.lane, e.at);
          end
        end
      end
    end
    if (round_done === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected round_done at cycle %0d, required none", cyc);
      end else if (rd_q[0] != cyc) begin
        errors++;
        $display("FAIL round_done time: cycle %0d, required cycle %0d", cyc, rd_q[0]);
        void'(rd_q.pop_front());
      end else begin
        void'(rd_q.pop_front());
      end
    end
  end

  // Two staggered lanes finishing normally: used for the basic and post-reset runs
  task automatic scenario_basic(input string name);
    int t0;
    scn = name;
    t0 = cyc;
    push_start(0, t0 + 2);
    push_start(1, t0 + 7);
    rd_q.push_back(t0 + 14);
    tbl.push_back(drv(0, 0, 1, 10'h003, 10'h000, 0));
    tbl.push_back(chk(0, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(drv(1, 0, 0, 10'h003, 10'h000, 0));
    tbl.push_back(chk(1, 10'h000, 10'h000, 1, 0, 0));
    tbl.push_back(drv(10, 0, 0, 10'h003, 10'h001, 0));
    tbl.push_back(chk(11, 10'h001, 10'h000, 1, 0, 0));
    tbl.push_back(drv(12, 0, 0, 10'h003, 10'h003, 0));
    tbl.push_back(chk(13, 10'h003, 10'h000, 1, 0, 0));
    tbl.push_back(chk(14, 10'h003, 10'h000, 0, 1, 0));
    tbl.push_back(chk(15, 10'h003, 10'h000, 0, 0, 0));
    tbl.push_back(drv(15, 0, 0, 10'h003, 10'h000, 0));
    run_table(16);
  endtask

  initial begin
    rst             = 1'b1;
    trigger         = 1'b0;
    en_bits         = '0;
    timeout_cfg     = '0;
    clear_flags     = 1'b0;
    sensor_done_raw = '0;
    for (int i = 0; i < NS; i++) dly[i] = 16'(i + 1);
    dly[0] = 16'd0;
    dly[1] = 16'd5;
    dly[2] = 16'd3;
    dly[3] = 16'd20;

    repeat (3) @(negedge clk);
    cmp("reset start", 32'(sensor_start), 32'h0);
    cmp("reset done", 32'(sensor_done), 32'h0);
    cmp("reset flags", 32'(timeout_flags), 32'h0);
    cmp("reset status", {29'h0, overrun, busy, round_done}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic staggered round, no timeout
    scenario_basic("basic");

    // Timeout on a silent lane, then clear
    begin
      int t0;
      scn = "timeout";
      timeout_cfg = 16'd20;
      t0 = cyc;
      push_start(2, t0 + 5);
      rd_q.push_back(t0 + 23);
      tbl.push_back(drv(0, 0, 1, 10'h004, 10'h000, 0));
      tbl.push_back(drv(1, 0, 0, 10'h004, 10'h000, 0));
      tbl.push_back(chk(21, 10'h000, 10'h000, 1, 0, 0));
      tbl.push_back(chk(22, 10'h004, 10'h004, 1, 0, 0));
      tbl.push_back(chk(23, 10'h004, 10'h004, 0, 1, 0));
      tbl.push_back(chk(24, 10'h004, 10'h004, 0, 0, 0));
      tbl.push_back(drv(24, 0, 0, 10'h004, 10'h000, 1));
      tbl.push_back(drv(25, 0, 0, 10'h004, 10'h000, 0));
      tbl.push_back(chk(25, 10'h004, 10'h000, 0, 0, 0));
      run_table(26);
    end

    // Done edge in the exact timeout cycle: done wins, no flag
    begin
      int t0;
      scn = "edge_vs_timeout";
      t0 = cyc;
      push_start(2, t0 + 5);
      rd_q.push_back(t0 + 23);
      tbl.push_back(drv(0, 0, 1, 10'h004, 10'h000, 0));
      tbl.push_back(drv(1, 0, 0, 10'h004, 10'h000, 0));
      tbl.push_back(drv(21, 0, 0, 10'h004, 10'h004, 0));
      tbl.push_back(chk(22, 10'h004, 10'h000, 1, 0, 0));
      tbl.push_back(chk(23, 10'h004, 10'h000, 0, 1, 0));
      tbl.push_back(drv(24, 0, 0, 10'h004, 10'h000, 0));
      run_table(25);
    end

    // Delay equal to timeout: lane never starts, closed by timeout
    begin
      int t0;
      scn = "delay_eq_timeout";
      t0 = cyc;
      rd_q.push_back(t0 + 23);
      tbl.push_back(drv(0, 0, 1, 10'h008, 10'h000, 0));
      tbl.push_back(drv(1, 0, 0, 10'h008, 10'h000, 0));
      tbl.push_back(chk(21, 10'h000, 10'h000, 1, 0, 0));
      tbl.push_back(chk(22, 10'h008, 10'h008, 1, 0, 0));
      tbl.push_back(chk(23, 10'h008, 10'h008, 0, 1, 0));
      tbl.push_back(drv(24, 0, 0, 10'h000, 10'h000, 1));
      tbl.push_back(drv(25, 0, 0, 10'h000, 10'h000, 0));
      tbl.push_back(chk(25, 10'h008, 10'h000, 0, 0, 0));
      run_table(26);
    end

    // Second trigger mid-round (with a same-cycle clear): overrun set, round unchanged
    begin
      int t0;
      scn = "overrun";
      timeout_cfg = 16'd0;
      t0 = cyc;
      push_start(0, t0 + 2);
      push_start(1, t0 + 7);
      rd_q.push_back(t0 + 14);
      tbl.push_back(drv(0, 0, 1, 10'h003, 10'h000, 0));
      tbl.push_back(drv(1, 0, 0, 10'h003, 10'h000, 0));
      tbl.push_back(drv(3, 0, 1, 10'h3FF, 10'h000, 1));
      tbl.push_back(drv(4, 0, 0, 10'h003, 10'h000, 0));
      tbl.push_back(chk(4, 10'h000, 10'h000, 1, 0, 1));
      tbl.push_back(drv(10, 0, 0, 10'h003, 10'h001, 0));
      tbl.push_back(drv(12, 0, 0, 10'h003, 10'h003, 0));
      tbl.push_back(chk(13, 10'h003, 10'h000, 1, 0, 1));
      tbl.push_back(chk(14, 10'h003, 10'h000, 0, 1, 1));
      tbl.push_back(drv(15, 0, 0, 10'h003, 10'h000, 1));
      tbl.push_back(drv(16, 0, 0, 10'h003, 10'h000, 0));
      tbl.push_back(chk(16, 10'h003, 10'h000, 0, 0, 0));
      run_table(17);
    end

    // Trigger with no enables is ignored; previous done levels hold
    begin
      scn = "no_enables";
      tbl.push_back(drv(0, 0, 1, 10'h000, 10'h000, 0));
      tbl.push_back(chk(1, 10'h003, 10'h000, 0, 0, 0));
      tbl.push_back(drv(1, 0, 0, 10'h000, 10'h000, 0));
      tbl.push_back(chk(5, 10'h003, 10'h000, 0, 0, 0));
      run_table(6);
    end

    // Reset mid-round: everything clears, no round_done, only the pre-reset start
    begin
      int t0;
      scn = "mid_reset";
      t0 = cyc;
      push_start(0, t0 + 2);
      tbl.push_back(drv(0, 0, 1, 10'h003, 10'h000, 0));
      tbl.push_back(drv(1, 0, 0, 10'h003, 10'h000, 0));
      tbl.push_back(drv(2, 0, 1, 10'h003, 10'h000, 0));
      tbl.push_back(chk(3, 10'h000, 10'h000, 1, 0, 1));
      tbl.push_back(drv(3, 1, 0, 10'h003, 10'h000, 0));
      tbl.push_back(chk(4, 10'h000, 10'h000, 0, 0, 0));
      tbl.push_back(drv(4, 0, 0, 10'h003, 10'h000, 0));
      tbl.push_back(chk(12, 10'h000, 10'h000, 0, 0, 0));
      run_table(13);
    end

    // Fresh round after reset behaves like the basic one
    scenario_basic("after_reset");

    repeat (3) @(negedge clk);
    cmp("start events left", 32'(start_q.size()), 32'h0);
    cmp("round_done events left", 32'(rd_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_trigger_sequencer.md
Name: sensor_trigger_sequencer

Overview:
- Converts the single acquisition trigger into staggered per-sensor start pulses, one programmable delay per sensor.
- Tracks each started sensor's completion and applies a shared timeout so a dead sensor cannot stall the round.
- Presents sticky per-sensor done levels to the timing manager's done inputs.
- Sits between the timing manager's trigger output and the ADC, encoder, AMDS and eddy-current sensor interface blocks.

Parameters:
- N_SENSORS, 10, number of sensor lanes; bit order matches the timing manager enable bits (0 = ADC, 1 = encoder, 2-5 = AMDS 0-3, 6-9 = eddy 0-3).
- CNT_W, 16, width of the elapsed counter, delay fields and timeout field.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- trigger  in  1  one-cycle round-start pulse
- en_bits  in  N_SENSORS  sensor enables, latched at round start
- delay_cfg  in  N_SENSORS*CNT_W  per-sensor start delay in clocks; lane i is bits [i*CNT_W +: CNT_W]
- timeout_cfg  in  CNT_W  round timeout in clocks; 0 = timeout disabled
- clear_flags  in  1  clears timeout_flags and overrun
- sensor_done_raw  in  N_SENSORS  done levels from the sensor IPs
- sensor_start  out  N_SENSORS  one-cycle start pulses to the sensors
- sensor_done  out  N_SENSORS  sticky done levels, to the timing manager
- timeout_flags  out  N_SENSORS  sticky per-sensor timeout indicators
- overrun  out  1  sticky: trigger arrived while a round was active
- busy  out  1  round in progress
- round_done  out  1  one-cycle pulse at round end

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: every output is 0; state = IDLE; elapsed counter = 0; en_q = 0; started = 0; raw-done edge flops = 0. Reset mid-round abandons the round and emits no round_done.
- FSM states: IDLE, RUN, DONE.

IDLE:
- Condition: trigger=1 and en_bits != 0 in cycle T.
  - Latch en_q <= en_bits.
  - Set elapsed <= 0, sensor_done <= 0, started <= 0.
  - Go to RUN; busy = 1 from cycle T+1.
- Condition: trigger=1 and en_bits == 0.
  - Ignored; no state change, no round_done.

RUN, evaluated each cycle:
- Lane start, for lane i with en_q[i] and !started[i] and elapsed == delay_i:
  - sensor_start[i] is high for exactly cycle T+2+delay_i.
  - started[i] is set.
- Delay beyond the timeout: if delay_i >= timeout_cfg and timeout_cfg != 0, the lane never starts.
- Done edges:
  - Rising edge of sensor_done_raw[i] (internal 1-cycle edge flop) on a started, enabled lane sets sensor_done[i] the next cycle.
  - Edges on unstarted or disabled lanes are ignored.
- All done: when every en_q lane has sensor_done set, the FSM enters DONE.
- elapsed increments by 1 per cycle and saturates at all-ones; no wrap.
- Timeout: when timeout_cfg != 0 and elapsed == timeout_cfg, every en_q lane whose sensor_done is clear gets timeout_flags[i] <= 1 and sensor_done[i] <= 1, including unstarted lanes. The FSM then enters DONE.
- Simultaneous done edge and timeout on a lane: the done edge wins; timeout_flags[i] stays 0.
- Trigger received in RUN or DONE: sets overrun and is otherwise ignored.

DONE:
- round_done = 1 for one cycle; busy = 0 in that cycle; return to IDLE.
- sensor_done holds until the next accepted trigger.
- Minimum trigger-to-trigger spacing is therefore the round length + 1.

Flags:
- clear_flags clears timeout_flags and overrun.
- A set event in the same cycle wins over clear_flags.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, RUN, DONE).
  - CNT_W default.
  - Sensor index constants (ADC=0 … EDDY_3=9), shared with the driver-side enumeration.
- Sub-module sensor_seq_lane, instantiated N_SENSORS times in a generate loop:
  - Inputs: en, delay, elapsed, run, round_start, timeout_hit, clear.
  - Owns started, done, timeout flag, raw-done edge flop and start pulse.
- The top level owns the FSM, the elapsed counter, the all-done reduction and overrun.

Test Plan:
- en_bits=0x003, delay0=0, delay1=5, timeout 0, trigger at T -> sensor_start[0] at T+2, sensor_start[1] at T+7; done_raw edges at T+10 and T+12 -> sensor_done=0x003 at T+13, round_done at T+14, busy low.
- en_bits=0x004, delay2=3, timeout_cfg=20, no done -> at cycle T+22 timeout_flags=0x004, sensor_done=0x004, round_done next cycle; clear_flags -> timeout_flags=0.
- Done edge on lane 2 in the same cycle elapsed==timeout_cfg -> sensor_done[2]=1, timeout_flags[2]=0.
- Second trigger during RUN -> overrun=1, no extra starts, round completes normally.
- trigger with en_bits=0 -> no sensor_start, busy=0, no round_done.
- rst asserted mid-RUN -> all outputs 0 the next cycle, no round_done; a fresh trigger behaves as in scenario 1.
